// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped UART transmitter with a small TX FIFO.
// CPU stores land in the FIFO; a shifter drains it as 8N1 frames on tx, LSB first.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | tx high; pops the FIFO head when data is waiting
// START   | tx low for one bit period
// DATA    | tx = shreg[0]; shift right at each bit end, 8 bits total
// PARITY  | tx = XOR of the 8 data bits (only with UART_TX_PARITY_EN)
// STOP    | tx high for one bit period, then back to IDLE
module uart_tx_io #(
  parameter int CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_cs,
  input  logic             uart_wen,
  input  logic [7:0]       uart_wdata,
  input  logic             clr_ovf,
  output logic             tx,
  output logic             busy,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             push, push_ok, pop;

  state_t           state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             baud_tc;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign push    = uart_cs & uart_wen;
  assign push_ok = push & ~full_q;
  assign baud_tc = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // FIFO pointer, occupancy and sticky overflow next-state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ovf_d   = ovf_q;
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    if (push_ok) wptr_d = wptr_q + PTR_W'(1);
    if (pop)     rptr_d = rptr_q + PTR_W'(1);
    if (clr_ovf) ovf_d = 1'b0;
    // a dropped push outranks a same-cycle clear
    if (push && full_q) ovf_d = 1'b1;
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wptr_q] <= uart_wdata;
  end

  // Shifter next-state; tx_d is derived from the next state so tx is a clean flop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          shreg_d = fifo_mem[rptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_mem[rptr_q];
`endif
        end
      end
      S_START: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Shifter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) | ~empty_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Table of single-byte frames checked cycle by cycle, then hand sequences for
// back-to-back frames, overflow handling and reset mid-frame.
module tb_uart_tx_io;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * CPB;
  localparam int NV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_cs = 1'b0;
  logic       uart_wen = 1'b0;
  logic [7:0] uart_wdata = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       tx, busy, fifo_full, fifo_empty, overflow;
  logic [3:0] fifo_count;

  uart_tx_io #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .uart_cs(uart_cs), .uart_wen(uart_wen),
    .uart_wdata(uart_wdata), .clr_ovf(clr_ovf), .tx(tx), .busy(busy),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // frame[k] is the k-th bit on the wire: start, d0..d7, [parity], stop
  typedef struct {
    logic [7:0]    data;
    logic [NB-1:0] frame;
  } vec_t;
  vec_t vecs[NV];

  // Independent 8N1 receiver: samples mid-bit, collects decoded bytes
  logic [7:0] mon_q[$];
  logic [7:0] mon_sh;
  bit         mon_active;
  int         mon_k, mon_idx, mon_err;
  initial begin
    mon_active = 0; mon_k = 0; mon_sh = 8'h00; mon_err = 0; mon_idx = 0;
    forever begin
      @(negedge clk or negedge rst);
      if (rst !== 1'b1) begin
        mon_active = 0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1;
          mon_k = 0;
        end
      end else begin
        mon_k++;
        if ((mon_k % CPB) == CPB / 2) begin
          mon_idx = mon_k / CPB;
          if (mon_idx == 0) begin
            if (tx !== 1'b0) mon_err++;
          end else if (mon_idx <= 8) begin
            mon_sh[mon_idx-1] = tx;
`ifdef UART_TX_PARITY_EN
          end else if (mon_idx == 9) begin
            if (tx !== ^mon_sh) mon_err++;
`endif
          end else begin
            if (tx !== 1'b1) mon_err++;
            mon_q.push_back(mon_sh);
            mon_active = 0;
          end
        end
      end
    end
  end

  task automatic push_one(input logic [7:0] d);
    uart_cs = 1'b1; uart_wen = 1'b1; uart_wdata = d;
    @(negedge clk);
    uart_cs = 1'b0; uart_wen = 1'b0;
  endtask

  logic [NB-1:0] bad;
  logic [7:0]    exp3 [3];
  int            lows, t;

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h07, 11'b1_1_0000_0111_0};
    vecs[1] = '{8'h03, 11'b1_0_0000_0011_0};
    vecs[2] = '{8'hA5, 11'b1_0_1010_0101_0};
    vecs[3] = '{8'h80, 11'b1_1_1000_0000_0};
`else
    vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[1] = '{8'h01, 10'b1_0000_0001_0};
    vecs[2] = '{8'h80, 10'b1_1000_0000_0};
    vecs[3] = '{8'hFF, 10'b1_1111_1111_0};
`endif
    exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h3C;

    // reset state and quiet idle line
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("idle_tx_low_cycles", 32'(lows), 0);
    chk("idle_busy", 32'(busy), 0);

    // single-byte frames, cycle-exact
    for (int v = 0; v < NV; v++) begin
      mon_q.delete();
      push_one(vecs[v].data);
      chk($sformatf("v%0d_tx_after_push_edge", v), 32'(tx), 1);
      chk($sformatf("v%0d_count_after_push", v), 32'(fifo_count), 1);
      chk($sformatf("v%0d_busy_after_push", v), 32'(busy), 1);
      @(negedge clk);
      chk($sformatf("v%0d_tx_falls_2nd_edge", v), 32'(tx), 0);
      chk($sformatf("v%0d_count_after_pop", v), 32'(fifo_count), 0);
      bad = '0;
      for (int k = 0; k < FRAME_CYC; k++) begin
        if (k > 0) @(negedge clk);
        if (tx !== vecs[v].frame[k/CPB]) bad[k/CPB] = 1'b1;
      end
      for (int b = 0; b < NB; b++)
        chk($sformatf("v%0d_frame_bit%0d_wrong", v, b), 32'(bad[b]), 0);
      @(negedge clk);
      chk($sformatf("v%0d_busy_after_frame", v), 32'(busy), 0);
      chk($sformatf("v%0d_tx_idle_after_frame", v), 32'(tx), 1);
      chk($sformatf("v%0d_rx_count", v), 32'(mon_q.size()), 1);
      if (mon_q.size() > 0) chk($sformatf("v%0d_rx_byte", v), 32'(mon_q[0]), 32'(vecs[v].data));
    end

    // back-to-back: 0x00, 0xFF, 0x3C
    mon_q.delete();
    uart_cs = 1'b1; uart_wen = 1'b1; uart_wdata = 8'h00;
    @(negedge clk);
    chk("b2b_count_1", 32'(fifo_count), 1);
    uart_wdata = 8'hFF;
    @(negedge clk);
    chk("b2b_start0_tx", 32'(tx), 0);
    chk("b2b_count_after_pop", 32'(fifo_count), 1);
    uart_wdata = 8'h3C;
    @(negedge clk);
    chk("b2b_count_peak", 32'(fifo_count), 2);
    uart_cs = 1'b0; uart_wen = 1'b0;
    repeat (FRAME_CYC - 1) @(negedge clk);
    chk("b2b_gap1_tx", 32'(tx), 1);
    chk("b2b_gap1_busy", 32'(busy), 1);
    @(negedge clk);
    chk("b2b_start1_tx", 32'(tx), 0);
    repeat (FRAME_CYC) @(negedge clk);
    chk("b2b_gap2_tx", 32'(tx), 1);
    chk("b2b_gap2_count", 32'(fifo_count), 1);
    @(negedge clk);
    chk("b2b_start2_tx", 32'(tx), 0);
    chk("b2b_count_drained", 32'(fifo_count), 0);
    repeat (FRAME_CYC) @(negedge clk);
    chk("b2b_end_tx", 32'(tx), 1);
    chk("b2b_end_busy", 32'(busy), 0);
    chk("b2b_rx_count", 32'(mon_q.size()), 3);
    for (int i = 0; i < 3; i++)
      if (i < mon_q.size()) chk($sformatf("b2b_rx_byte%0d", i), 32'(mon_q[i]), 32'(exp3[i]));

    // overflow: 10 pushes, first is popped, 8 fill the FIFO, last dropped
    mon_q.delete();
    uart_cs = 1'b1; uart_wen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      uart_wdata = 8'h10 + 8'(i);
      @(negedge clk);
      if (i == 8) begin
        chk("ovf_full_at_8", 32'(fifo_full), 1);
        chk("ovf_count_at_8", 32'(fifo_count), 8);
        chk("ovf_not_yet", 32'(overflow), 0);
      end
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count_held", 32'(fifo_count), 8);
    uart_cs = 1'b0; uart_wen = 1'b0; clr_ovf = 1'b1;
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow), 0);
    uart_cs = 1'b1; uart_wen = 1'b1; uart_wdata = 8'hEE; clr_ovf = 1'b1;
    @(negedge clk);
    chk("ovf_set_beats_clear", 32'(overflow), 1);
    chk("ovf_count_still_8", 32'(fifo_count), 8);
    uart_cs = 1'b0; uart_wen = 1'b0; clr_ovf = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("ovf_drain_busy", 32'(busy), 0);
    chk("ovf_rx_count", 32'(mon_q.size()), 9);
    for (int i = 0; i < 9; i++)
      if (i < mon_q.size()) chk($sformatf("ovf_rx_byte%0d", i), 32'(mon_q[i]), 32'h10 + 32'(i));

    // reset in the middle of bit 3 of 0x55 with three bytes queued
    mon_q.delete();
    uart_cs = 1'b1; uart_wen = 1'b1; uart_wdata = 8'h55;
    @(negedge clk);
    uart_wdata = 8'h11;
    @(negedge clk);
    uart_wdata = 8'h22;
    @(negedge clk);
    uart_wdata = 8'h33;
    @(negedge clk);
    uart_cs = 1'b0; uart_wen = 1'b0;
    chk("rstmid_count_3", 32'(fifo_count), 3);
    repeat (CPB * 4 + 1 - 2) @(negedge clk);
    chk("rstmid_bit3_tx", 32'(tx), 0);
    rst = 1'b0;
    #1;
    chk("rstmid_tx", 32'(tx), 1);
    chk("rstmid_empty", 32'(fifo_empty), 1);
    chk("rstmid_count", 32'(fifo_count), 0);
    chk("rstmid_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("rstmid_no_tx_after", 32'(lows), 0);
    chk("rstmid_rx_count", 32'(mon_q.size()), 0);
    chk("rx_frame_errors", 32'(mon_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_io.md
Name: uart_tx_io

Overview:
- Memory-mapped UART transmitter peripheral; the transmit-direction counterpart of the UART programming receiver on the CPU side.
- The CPU stores bytes through the io decode path into a small TX FIFO.
- The block serializes each byte as 8N1 on `tx`, LSB first.
- Status flags are available to the io read mux, so software can poll before writing.

Parameters:
- CLKS_PER_BIT, 200, clock cycles per serial bit period (≥2).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2.
- CNT_W, 4, width of `fifo_count`; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  in  1  system clock (same domain as CPU `clock`).
- rst  in  1  asynchronous reset, active-low.
- uart_cs  in  1  chip select from io address decode.
- uart_wen  in  1  store strobe; a push occurs when `uart_cs & uart_wen` is high for one cycle.
- uart_wdata  in  8  byte to transmit (low byte of the store data).
- clr_ovf  in  1  synchronous clear of `overflow`.
- tx  out  1  serial output; idle high.
- busy  out  1  high when the FIFO is non-empty or the shifter is not IDLE.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- fifo_count  out  CNT_W  current occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky flag: a push was dropped because the FIFO was full.

Behaviour:

Reset (rst=0, asynchronous):
- tx=1, FIFO pointers and count = 0, fifo_empty=1, fifo_full=0, busy=0, overflow=0.
- State = IDLE; baud counter and bit index = 0.
- Reset asserted mid-frame aborts the frame immediately; tx returns high with no stop bit.

FIFO:
- Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits; pointers wrap modulo depth.
- A push is accepted when push=1 and fifo_full=0 (flag value before the edge).
- When push=1 and fifo_full=1, the data is dropped and overflow is set to 1, even if a pop occurs on the same edge.
- Push and pop on the same edge (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- overflow: if clr_ovf and a new overflow occur on the same cycle, set wins.
- Flags and count are registered and consistent with the FIFO contents after every edge.

Shifter FSM (states IDLE, START, DATA, STOP):
- IDLE: tx=1. If fifo_empty=0, pop the head into an 8-bit shift register, clear the baud counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shreg[0] for CLKS_PER_BIT cycles per bit. At each bit end, shift right. After bit index 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1; terminal count ends the current bit period.
- tx is driven from a register (glitch-free).

Latency and timing:
- A push into an empty FIFO while IDLE: tx falls on the 2nd rising edge after the strobe edge (edge 1 pushes, edge 2 pops and enters START).
- Frame length is 10·CLKS_PER_BIT cycles.
- Back-to-back bytes have exactly 1 IDLE cycle between the end of STOP and the next START.

Busy:
- `busy` is combinational from registered state: `(state != IDLE) | ~fifo_empty`.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11·CLKS_PER_BIT cycles.
- Undefined: no PARITY state or logic; the frame is 8N1 exactly as above.

Test Plan:
- Reset, CLKS_PER_BIT=4 -> tx=1, fifo_empty=1, busy=0, fifo_count=0; hold 100 cycles with no pushes -> tx stays 1.
- Push 0xA5 while IDLE -> tx=0 starting on the 2nd edge after the strobe.
  - Then tx carries 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each, followed by a stop bit of 4 cycles high.
  - busy falls after STOP; total 40 cycles from tx falling.
- Push 0x00, 0xFF, 0x3C back-to-back -> fifo_count peaks at 2 (one byte already popped).
  - Three frames are sent with a 1-cycle idle gap between them; the decoded bytes match in order.
- Push 9 bytes with DEPTH=8 while a frame is in progress -> one byte accepted by the pop, then FIFO full.
  - The 10th push is dropped and overflow=1.
  - Pulse clr_ovf -> overflow=0.
  - Repeat with clr_ovf and a dropped push on the same cycle -> overflow stays 1.
- Assert rst mid-DATA (bit 3 of 0x55) with 3 bytes queued -> tx=1 immediately, fifo_empty=1, fifo_count=0.
  - After release, no further transmission occurs.
- With UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1, frame 44 cycles.
  - Send 0x03 -> parity bit=0.
